// File: rtl/dvi_pkg.sv
// Shared DVI/TMDS definitions: symbol width, disparity counter width,
// control tokens and small helpers used by the encoder pipeline.
package dvi_pkg;

    localparam int unsigned TMDS_W = 10;
    localparam int unsigned CNT_W  = 5;

    localparam logic [TMDS_W-1:0] TOK_C00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] TOK_C01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] TOK_C10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] TOK_C11 = 10'b1010101011;

    // Running disparity, two's complement, wraps rather than saturates
    typedef logic signed [CNT_W-1:0] disp_t;

    // Which stage-2 encoding rule applies to the current symbol
    typedef enum logic [1:0] {
        ENC_CTRL,   // blanking: emit control token, clear disparity
        ENC_BAL,    // disparity zero or word balanced
        ENC_INV,    // invert data bits to pull disparity back
        ENC_DIR     // send data bits as-is
    } enc_sel_e;

    function automatic logic [TMDS_W-1:0] ctrl_token(input logic c1, input logic c0);
        logic [TMDS_W-1:0] tok;
        unique case ({c1, c0})
            2'b00:   tok = TOK_C00;
            2'b01:   tok = TOK_C01;
            2'b10:   tok = TOK_C10;
            default: tok = TOK_C11;
        endcase
        return tok;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// TMDS stage 1: transition-minimised word q_m and its ones/zeros counts,
// registered together with de and the control bits.
module tmds_qm_stage
    import dvi_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [7:0] i_data,
    input  logic       i_de,
    input  logic       i_c0,
    input  logic       i_c1,
    output logic [8:0] o_qm,
    output logic [3:0] o_n1q,
    output logic [3:0] o_n0q,
    output logic       o_de,
    output logic       o_c0,
    output logic       o_c1
);

    logic [7:0] w_data;
    logic [3:0] w_n1;
    logic       w_use_xnor;
    logic [8:0] w_qm;
    logic [3:0] w_n1q;

    logic [8:0] r_qm;
    logic [3:0] r_n1q;
    logic [3:0] r_n0q;
    logic       r_de;
    logic       r_c0;
    logic       r_c1;

    // Build q_m; data is masked during blanking so unknown bytes never enter the pipe
    always_comb begin
        logic [8:0] qm;
        w_data     = i_de ? i_data : '0;
        w_n1       = popcount8(w_data);
        w_use_xnor = (w_n1 > 4'd4) || ((w_n1 == 4'd4) && !w_data[0]);
        qm         = '0;
        qm[0]      = w_data[0];
        for (int unsigned i = 1; i < 8; i++) begin
            qm[i] = w_use_xnor ? ~(qm[i-1] ^ w_data[i]) : (qm[i-1] ^ w_data[i]);
        end
        qm[8]      = ~w_use_xnor;
        w_qm       = qm;
        w_n1q      = popcount8(qm[7:0]);
    end

    // Stage-1 pipeline register
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_qm  <= '0;
            r_n1q <= '0;
            r_n0q <= '0;
            r_de  <= 1'b0;
            r_c0  <= 1'b0;
            r_c1  <= 1'b0;
        end else begin
            r_qm  <= w_qm;
            r_n1q <= w_n1q;
            r_n0q <= 4'd8 - w_n1q;
            r_de  <= i_de;
            r_c0  <= i_c0;
            r_c1  <= i_c1;
        end
    end

    assign o_qm  = r_qm;
    assign o_n1q = r_n1q;
    assign o_n0q = r_n0q;
    assign o_de  = r_de;
    assign o_c0  = r_c0;
    assign o_c1  = r_c1;

endmodule

// File: rtl/tmds_encoder.sv
// TMDS encoder for one DVI channel: stage 1 (q_m) in tmds_qm_stage,
// stage 2 (DC balancing against the running disparity) here.
module tmds_encoder
    import dvi_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_arst,
    input  logic [7:0]        i_data,
    input  logic              i_de,
    input  logic              i_c0,
    input  logic              i_c1,
    output logic [TMDS_W-1:0] o_tmds
);

    logic [8:0]        w_qm;
    logic [3:0]        w_n1q;
    logic [3:0]        w_n0q;
    logic              w_de;
    logic              w_c0;
    logic              w_c1;

    disp_t             w_diff;
    disp_t             w_two_q8;
    disp_t             w_two_nq8;
    logic              w_cnt_zero;
    logic              w_cnt_neg;
    logic              w_cnt_pos;
    enc_sel_e          w_sel;
    logic [TMDS_W-1:0] w_tmds_next;
    disp_t             w_cnt_next;

    disp_t             r_cnt;
    logic [TMDS_W-1:0] r_tmds;

    tmds_qm_stage u_qm (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_data (i_data),
        .i_de   (i_de),
        .i_c0   (i_c0),
        .i_c1   (i_c1),
        .o_qm   (w_qm),
        .o_n1q  (w_n1q),
        .o_n0q  (w_n0q),
        .o_de   (w_de),
        .o_c0   (w_c0),
        .o_c1   (w_c1)
    );

    // Choose the encoding rule from de, disparity sign and word balance
    always_comb begin
        w_cnt_zero = (r_cnt == '0);
        w_cnt_neg  = r_cnt[CNT_W-1];
        w_cnt_pos  = !w_cnt_neg && !w_cnt_zero;
        if (!w_de) begin
            w_sel = ENC_CTRL;
        end else if (w_cnt_zero || (w_n1q == w_n0q)) begin
            w_sel = ENC_BAL;
        end else if ((w_cnt_pos && (w_n1q > w_n0q)) || (w_cnt_neg && (w_n0q > w_n1q))) begin
            w_sel = ENC_INV;
        end else begin
            w_sel = ENC_DIR;
        end
    end

    // Output symbol and next disparity; all terms are 5-bit signed so nothing truncates
    always_comb begin
        w_diff      = disp_t'({1'b0, w_n1q}) - disp_t'({1'b0, w_n0q});
        w_two_q8    = disp_t'({3'b000, w_qm[8], 1'b0});
        w_two_nq8   = disp_t'({3'b000, ~w_qm[8], 1'b0});
        w_tmds_next = ctrl_token(w_c1, w_c0);
        w_cnt_next  = '0;
        unique case (w_sel)
            ENC_BAL: begin
                w_tmds_next = {~w_qm[8], w_qm[8], (w_qm[8] ? w_qm[7:0] : ~w_qm[7:0])};
                w_cnt_next  = w_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
            end
            ENC_INV: begin
                w_tmds_next = {1'b1, w_qm[8], ~w_qm[7:0]};
                w_cnt_next  = r_cnt + w_two_q8 - w_diff;
            end
            ENC_DIR: begin
                w_tmds_next = {1'b0, w_qm[8], w_qm[7:0]};
                w_cnt_next  = r_cnt + w_diff - w_two_nq8;
            end
            default: begin
                w_tmds_next = ctrl_token(w_c1, w_c0);
                w_cnt_next  = '0;
            end
        endcase
    end

    // Stage-2 register: symbol out and running disparity
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_tmds <= TOK_C00;
            r_cnt  <= '0;
        end else begin
            r_tmds <= w_tmds_next;
            r_cnt  <= w_cnt_next;
        end
    end

    assign o_tmds = r_tmds;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed and framed-random checks for tmds_encoder.
module tb_tmds_encoder;

    logic       i_clk = 1'b0;
    logic       i_arst;
    logic [7:0] i_data;
    logic       i_de;
    logic       i_c0;
    logic       i_c1;
    logic [9:0] o_tmds;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int          m_cnt = 0;

    tmds_encoder dut (
        .i_clk  (i_clk),
        .i_arst (i_arst),
        .i_data (i_data),
        .i_de   (i_de),
        .i_c0   (i_c0),
        .i_c1   (i_c1),
        .o_tmds (o_tmds)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Apply one input vector across a rising edge; outputs are read 1ns later
    task automatic cyc(input logic [7:0] d, input logic de, input logic [1:0] c);
        i_data = d;
        i_de   = de;
        {i_c1, i_c0} = c;
        @(posedge i_clk);
        #1;
    endtask

    // Behavioural encoder written straight from the symbol rules, integer disparity
    task automatic ref_step(input logic [7:0] d, input logic de, input logic [1:0] c,
                            output logic [9:0] sym);
        int   n1, ones, zeros;
        logic xn, q8;
        logic [7:0] qm;
        n1    = $countones(d);
        xn    = (n1 > 4) || ((n1 == 4) && (d[0] == 1'b0));
        qm[0] = d[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        q8    = !xn;
        ones  = $countones(qm);
        zeros = 8 - ones;
        if (!de) begin
            case (c)
                2'd0:    sym = 10'b1101010100;
                2'd1:    sym = 10'b0010101011;
                2'd2:    sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
            m_cnt = 0;
        end else if ((m_cnt == 0) || (ones == zeros)) begin
            sym   = {~q8, q8, (q8 ? qm : ~qm)};
            m_cnt = m_cnt + (q8 ? (ones - zeros) : (zeros - ones));
        end else if (((m_cnt > 0) && (ones > zeros)) || ((m_cnt < 0) && (zeros > ones))) begin
            sym   = {1'b1, q8, ~qm};
            m_cnt = m_cnt + (q8 ? 2 : 0) + (zeros - ones);
        end else begin
            sym   = {1'b0, q8, qm};
            m_cnt = m_cnt + (ones - zeros) - (q8 ? 0 : 2);
        end
    endtask

    function automatic logic [7:0] decode(input logic [9:0] s);
        logic [7:0] q, o;
        q    = s[9] ? ~s[7:0] : s[7:0];
        o[0] = q[0];
        for (int i = 1; i < 8; i++) o[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        return o;
    endfunction

    initial begin
        logic [9:0] want, pwant;
        logic [7:0] d, pdata;
        logic [1:0] c;
        logic       de, pde, have_prev;
        int         pcnt, dsum;

        i_arst = 1'b1;
        i_data = 8'h00;
        i_de   = 1'b0;
        i_c0   = 1'b0;
        i_c1   = 1'b0;
        #3;
        chk("reset_token", o_tmds, 10'h354);
        @(posedge i_clk);
        #1;
        i_arst = 1'b0;

        // Control tokens, data byte must be ignored while blanking
        cyc(8'hA5, 1'b0, 2'd0);
        cyc(8'hA5, 1'b0, 2'd1); chk("ctl00", o_tmds, 10'h354);
        cyc(8'h5A, 1'b0, 2'd2); chk("ctl01", o_tmds, 10'h0AB);
        cyc(8'hFF, 1'b0, 2'd3); chk("ctl10", o_tmds, 10'h154);
        cyc(8'h00, 1'b0, 2'd0); chk("ctl11", o_tmds, 10'h2AB);

        // Disparity chain through all three data rules
        cyc(8'hFF, 1'b1, 2'd0); chk("blank_before", o_tmds, 10'h354);
        cyc(8'h00, 1'b1, 2'd0); chk("ff_cnt0",   o_tmds, 10'h200);
        cyc(8'h55, 1'b1, 2'd0); chk("00_cntm8",  o_tmds, 10'h3FF);
        cyc(8'h00, 1'b1, 2'd0); chk("55_bal",    o_tmds, 10'h133);
        cyc(8'hFF, 1'b1, 2'd0); chk("00_cntp2",  o_tmds, 10'h100);
        cyc(8'hFF, 1'b1, 2'd0); chk("ff_cntm6",  o_tmds, 10'h0FF);
        cyc(8'h00, 1'b0, 2'd0); chk("ff_cnt0b",  o_tmds, 10'h200);

        // Two zero bytes from cnt=0
        cyc(8'h00, 1'b1, 2'd0); chk("blank_tok", o_tmds, 10'h354);
        cyc(8'h00, 1'b1, 2'd0); chk("zero_1",    o_tmds, 10'h100);
        cyc(8'h00, 1'b0, 2'd0); chk("zero_2",    o_tmds, 10'h3FF);

        // Blanking clears disparity: 5 data symbols, one blank, then data
        cyc(8'h00, 1'b1, 2'd0); chk("bl_tok",  o_tmds, 10'h354);
        cyc(8'h00, 1'b1, 2'd0); chk("bl_d1",   o_tmds, 10'h100);
        cyc(8'h00, 1'b1, 2'd0); chk("bl_d2",   o_tmds, 10'h3FF);
        cyc(8'h00, 1'b1, 2'd0); chk("bl_d3",   o_tmds, 10'h100);
        cyc(8'h00, 1'b1, 2'd0); chk("bl_d4",   o_tmds, 10'h3FF);
        cyc(8'h00, 1'b0, 2'd0); chk("bl_d5",   o_tmds, 10'h100);
        cyc(8'h00, 1'b1, 2'd0); chk("bl_gap",  o_tmds, 10'h354);
        cyc(8'h00, 1'b0, 2'd0); chk("bl_after", o_tmds, 10'h100);

        // Reset during active video
        cyc(8'h00, 1'b1, 2'd0);
        cyc(8'h00, 1'b1, 2'd0); chk("pre_rst1", o_tmds, 10'h100);
        cyc(8'h00, 1'b1, 2'd0); chk("pre_rst2", o_tmds, 10'h3FF);
        i_arst = 1'b1;
        #1;
        chk("rst_async", o_tmds, 10'h354);
        @(posedge i_clk);
        #1;
        i_arst = 1'b0;
        chk("rst_hold", o_tmds, 10'h354);
        cyc(8'h00, 1'b1, 2'd0); chk("rst_fill",  o_tmds, 10'h354);
        cyc(8'h00, 1'b1, 2'd0); chk("post_rst1", o_tmds, 10'h100);
        cyc(8'h00, 1'b1, 2'd0); chk("post_rst2", o_tmds, 10'h3FF);

        // Framed random run: 16 blank + 64 active per line
        m_cnt     = 0;
        have_prev = 1'b0;
        pwant     = '0;
        pdata     = '0;
        pde       = 1'b0;
        pcnt      = 0;
        dsum      = 0;
        for (int t = 0; t < 3200; t++) begin
            de = ((t % 80) >= 16);
            d  = 8'($urandom);
            c  = 2'($urandom);
            ref_step(d, de, c, want);
            cyc(d, de, c);
            if (have_prev) begin
                chk("rnd_sym", o_tmds, pwant);
                if (pde) begin
                    chk("rnd_dec", decode(o_tmds), pdata);
                    dsum = dsum + 2 * $countones(o_tmds) - 10;
                    if (!de) begin
                        chk("rnd_disp", dsum, pcnt);
                        dsum = 0;
                    end
                end
            end
            have_prev = 1'b1;
            pwant     = want;
            pdata     = d;
            pde       = de;
            pcnt      = m_cnt;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
